// File: rtl/seg_display_scanner_if.sv
// Bus between the display scanner and its client: digit codes in, scanned decoder code and anodes out.
interface seg_display_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic                    load;
   logic [3:0]              digit_out;
   logic [NUM_DIGITS-1:0]   an_n;
   logic                    frame_done;

   modport master (
      output digits_in, load,
      input  digit_out, an_n, frame_done
   );

   modport slave (
      input  digits_in, load,
      output digit_out, an_n, frame_done
   );
endinterface

// File: rtl/seg_display_scanner.sv
// Multiplexed 7-segment scanner with per-slot dead time and double-buffered digit values.
// Define SEG_SCANNER_LZ_BLANK_EN to blank leading zeros when a new frame is latched.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_BLANK | dead time at slot start, all anodes off
//  ST_SHOW  | anode of current digit on, shadow digit shown
module seg_display_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   seg_display_scanner_if.slave   bus
);
   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   logic [CNT_W-1:0]                cnt, cnt_nxt;
   logic [IDX_W-1:0]                idx, idx_nxt;
   logic [0:0]                      state, state_nxt;
   logic [NUM_DIGITS-1:0][3:0]      pending;
   logic                            pending_valid;
   logic [NUM_DIGITS-1:0][3:0]      shadow, shadow_nxt, stored_calc;
   logic [NUM_DIGITS-1:0]           hide, hide_nxt, hide_calc;
   logic [NUM_DIGITS-1:0]           an_r, an_nxt;
   logic [3:0]                      digit_r, digit_nxt;
   logic                            fd_r, fd_nxt;
   logic                            last_slot, frame_wrap;

`ifdef SEG_SCANNER_LZ_BLANK_EN
   // Scan from the most significant digit; a zero stays "leading" while everything above it is 0 or blank.
   always_comb begin : lz_scan
      logic leading;
      leading     = 1'b1;
      stored_calc = pending;
      hide_calc   = '0;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         if (leading && pending[k] == 4'h0) begin
            stored_calc[k] = 4'hF;
            hide_calc[k]   = 1'b1;
         end
         leading = leading && (pending[k] == 4'h0 || pending[k] >= 4'hD);
      end
   end
`else
   assign stored_calc = pending;
   assign hide_calc   = '0;
`endif

   assign last_slot  = (cnt == PRE_END);
   assign frame_wrap = last_slot && (idx == IDX_MAX);

   // Outputs are registered from next-cycle values so they line up with cnt/idx of the same cycle.
   always_comb begin
      cnt_nxt = last_slot ? '0 : cnt + 1'b1;
      idx_nxt = idx;
      if (last_slot) idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;

      state_nxt = state;
      case (state)
         ST_BLANK: if (cnt_nxt == BLANK_END) state_nxt = ST_SHOW;
         ST_SHOW:  if (last_slot) state_nxt = ST_BLANK;
         default:  state_nxt = ST_BLANK;
      endcase

      shadow_nxt = shadow;
      hide_nxt   = hide;
      if (frame_wrap && pending_valid) begin
         shadow_nxt = stored_calc;
         hide_nxt   = hide_calc;
      end

      an_nxt    = '1;
      digit_nxt = 4'hF;
      if (state_nxt == ST_SHOW && !hide_nxt[idx_nxt]) begin
         an_nxt[idx_nxt] = 1'b0;
         digit_nxt       = shadow_nxt[idx_nxt];
      end
      fd_nxt = (cnt_nxt == PRE_END) && (idx_nxt == IDX_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         idx           <= '0;
         state         <= ST_BLANK;
         pending       <= '1;
         pending_valid <= 1'b0;
         shadow        <= '1;
         hide          <= '0;
         an_r          <= '1;
         digit_r       <= 4'hF;
         fd_r          <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         state  <= state_nxt;
         shadow <= shadow_nxt;
         hide   <= hide_nxt;
         if (bus.load) pending <= bus.digits_in;
         // A load on the wrap cycle re-arms pending after the old contents move to shadow.
         pending_valid <= bus.load | (pending_valid & ~frame_wrap);
         an_r    <= an_nxt;
         digit_r <= digit_nxt;
         fd_r    <= fd_nxt;
      end
   end

   assign bus.an_n       = an_r;
   assign bus.digit_out  = digit_r;
   assign bus.frame_done = fd_r;
endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench: constant vectors, directed multi-frame sequences and a random run against a cycle model.
module tb_seg_display_scanner;
   localparam int N  = 4;
   localparam int P  = 8;
   localparam int B  = 2;
   localparam int P2 = 3;
   localparam int B2 = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_display_scanner_if #(.NUM_DIGITS(N)) bus ();
   seg_display_scanner_if #(.NUM_DIGITS(N)) bus2 ();

   seg_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   seg_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P2), .BLANK_CYCLES(B2)) u_dut_p3 (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   int tests = 0;
   int fails = 0;
   int t = 0;
   bit model_ok = 1'b0;
   logic [3:0] m_pend[N];
   logic [3:0] m_shad[N];
   bit         m_hide[N];
   bit         m_valid;
   logic [3:0] obs_an, obs_dig;
   logic       obs_fd, obs_fd2;
   logic [3:0] rec_an[96];
   logic [3:0] rec_dig[96];
   logic       rec_fd2[96];

   typedef struct {
      int         ld_cyc;
      logic [15:0] ld_val;
      int         at;
      logic [3:0] an;
      logic [3:0] dig;
      logic       fd;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 4'hF;
         m_shad[i] = 4'hF;
         m_hide[i] = 1'b0;
      end
      m_valid = 1'b0;
      t = 0;
   endfunction

   function automatic void model_transfer();
      bit lead;
      for (int k = 0; k < N; k++) begin
         m_shad[k] = m_pend[k];
         m_hide[k] = 1'b0;
      end
`ifdef SEG_SCANNER_LZ_BLANK_EN
      for (int k = 1; k < N; k++) begin
         lead = (m_pend[k] == 4'h0);
         for (int j = k + 1; j < N; j++)
            if (!(m_pend[j] == 4'h0 || m_pend[j] >= 4'd13)) lead = 1'b0;
         if (lead) begin
            m_hide[k] = 1'b1;
            m_shad[k] = 4'hF;
         end
      end
`else
      lead = 1'b0;
      if (lead) m_hide[0] = 1'b0;
`endif
   endfunction

   // One clock cycle: drive inputs, check outputs of cycle t against the model, then advance the model.
   task automatic cyc(input logic ld, input logic [15:0] d, input logic r);
      int slot, pos;
      logic [3:0] ea, ed;
      logic ef;
      bus.load = ld;
      bus.digits_in = d;
      rst = r;
      @(negedge clk);
      obs_an  = bus.an_n;
      obs_dig = bus.digit_out;
      obs_fd  = bus.frame_done;
      obs_fd2 = bus2.frame_done;
      if (model_ok) begin
         slot = (t / P) % N;
         pos  = t % P;
         ea = 4'hF;
         ed = 4'hF;
         if (pos >= B && !m_hide[slot]) begin
            ea[slot] = 1'b0;
            ed = m_shad[slot];
         end
         ef = (t % (N * P) == N * P - 1);
         check("model_an_n", 16'(obs_an), 16'(ea));
         check("model_digit_out", 16'(obs_dig), 16'(ed));
         check("model_frame_done", 16'(obs_fd), 16'(ef));
         slot = (t / P2) % N;
         pos  = t % P2;
         ea = 4'hF;
         if (pos >= B2) ea[slot] = 1'b0;
         ef = (t % (N * P2) == N * P2 - 1);
         check("p3_an_n", 16'(bus2.an_n), 16'(ea));
         check("p3_digit_out", 16'(bus2.digit_out), 16'hF);
         check("p3_frame_done", 16'(obs_fd2), 16'(ef));
      end
      @(posedge clk);
      #1;
      if (r) begin
         model_reset();
         model_ok = 1'b1;
      end else begin
         if (t % (N * P) == N * P - 1 && m_valid) begin
            model_transfer();
            m_valid = 1'b0;
         end
         if (ld) begin
            for (int i = 0; i < N; i++) m_pend[i] = d[4*i +: 4];
            m_valid = 1'b1;
         end
         t++;
      end
   endtask

   initial begin
      logic [3:0] exp1[4];
      logic [3:0] exp2[4];
      int first_fd, second_fd, n_fd;
      logic ld, r;
      logic [15:0] d;

      bus2.load = 1'b0;
      bus2.digits_in = '0;
      bus.load = 1'b0;
      bus.digits_in = '0;

      vecs.push_back('{-1, 16'h0000,  0, 4'hF, 4'hF, 1'b0});
      vecs.push_back('{-1, 16'h0000,  1, 4'hF, 4'hF, 1'b0});
      vecs.push_back('{-1, 16'h0000,  2, 4'hE, 4'hF, 1'b0});
      vecs.push_back('{-1, 16'h0000,  7, 4'hE, 4'hF, 1'b0});
      vecs.push_back('{-1, 16'h0000,  8, 4'hF, 4'hF, 1'b0});
      vecs.push_back('{-1, 16'h0000, 10, 4'hD, 4'hF, 1'b0});
      vecs.push_back('{-1, 16'h0000, 18, 4'hB, 4'hF, 1'b0});
      vecs.push_back('{-1, 16'h0000, 26, 4'h7, 4'hF, 1'b0});
      vecs.push_back('{-1, 16'h0000, 31, 4'h7, 4'hF, 1'b1});
      vecs.push_back('{-1, 16'h0000, 32, 4'hF, 4'hF, 1'b0});
      vecs.push_back('{-1, 16'h0000, 63, 4'h7, 4'hF, 1'b1});
      vecs.push_back('{ 3, 16'hC942,  7, 4'hE, 4'hF, 1'b0});
      vecs.push_back('{ 3, 16'hC942, 33, 4'hF, 4'hF, 1'b0});
      vecs.push_back('{ 3, 16'hC942, 34, 4'hE, 4'h2, 1'b0});
      vecs.push_back('{ 3, 16'hC942, 39, 4'hE, 4'h2, 1'b0});
      vecs.push_back('{ 3, 16'hC942, 42, 4'hD, 4'h4, 1'b0});
      vecs.push_back('{ 3, 16'hC942, 50, 4'hB, 4'h9, 1'b0});
      vecs.push_back('{ 3, 16'hC942, 58, 4'h7, 4'hC, 1'b0});
      vecs.push_back('{ 3, 16'hC942, 63, 4'h7, 4'hC, 1'b1});
      vecs.push_back('{ 3, 16'h0070, 34, 4'hE, 4'h0, 1'b0});
      vecs.push_back('{ 3, 16'h0070, 42, 4'hD, 4'h7, 1'b0});
`ifdef SEG_SCANNER_LZ_BLANK_EN
      vecs.push_back('{ 3, 16'h0070, 50, 4'hF, 4'hF, 1'b0});
      vecs.push_back('{ 3, 16'h0070, 58, 4'hF, 4'hF, 1'b0});
`else
      vecs.push_back('{ 3, 16'h0070, 50, 4'hB, 4'h0, 1'b0});
      vecs.push_back('{ 3, 16'h0070, 58, 4'h7, 4'h0, 1'b0});
`endif

      cyc(1'b0, 16'h0, 1'b1);
      cyc(1'b0, 16'h0, 1'b1);

      foreach (vecs[i]) begin
         cyc(1'b0, 16'h0, 1'b1);
         for (int c = 0; c <= vecs[i].at; c++)
            cyc(c == vecs[i].ld_cyc, vecs[i].ld_val, 1'b0);
         check($sformatf("vec%0d_an_n", i), 16'(obs_an), 16'(vecs[i].an));
         check($sformatf("vec%0d_digit_out", i), 16'(obs_dig), 16'(vecs[i].dig));
         check($sformatf("vec%0d_frame_done", i), 16'(obs_fd), 16'(vecs[i].fd));
      end

      // Load on the frame_done cycle: old pending shows in frame 1, the late value in frame 2.
      exp1 = '{4'h8, 4'h7, 4'h6, 4'h5};
      exp2 = '{4'h4, 4'h3, 4'h2, 4'h1};
      cyc(1'b0, 16'h0, 1'b1);
      for (int c = 0; c < 96; c++) begin
         cyc(c == 10 || c == 31, (c == 10) ? 16'h5678 : 16'h1234, 1'b0);
         rec_an[c]  = obs_an;
         rec_dig[c] = obs_dig;
      end
      for (int k = 0; k < N; k++) begin
         check($sformatf("late_load_f1_dig%0d", k), 16'(rec_dig[32 + 8*k + 2]), 16'(exp1[k]));
         check($sformatf("late_load_f2_dig%0d", k), 16'(rec_dig[64 + 8*k + 2]), 16'(exp2[k]));
      end
      check("late_load_f1_an0", 16'(rec_an[34]), 16'hE);

      // Reset mid-frame discards the earlier load and restarts at slot 0.
      cyc(1'b0, 16'h0, 1'b1);
      for (int c = 0; c < 20; c++) cyc(c == 3, 16'hC942, 1'b0);
      cyc(1'b0, 16'h0, 1'b1);
      for (int c = 0; c < 64; c++) begin
         cyc(1'b0, 16'h0, 1'b0);
         rec_an[c]  = obs_an;
         rec_dig[c] = obs_dig;
      end
      check("rst_mid_an_c0", 16'(rec_an[0]), 16'hF);
      check("rst_mid_dig_c0", 16'(rec_dig[0]), 16'hF);
      check("rst_mid_an_c2", 16'(rec_an[2]), 16'hE);
      check("rst_mid_dig_c34", 16'(rec_dig[34]), 16'hF);
      check("rst_mid_dig_c58", 16'(rec_dig[58]), 16'hF);

      // Short-prescale instance: frame_done period of 12 cycles.
      cyc(1'b0, 16'h0, 1'b1);
      first_fd = -1;
      second_fd = -1;
      n_fd = 0;
      for (int c = 0; c < 24; c++) begin
         cyc(1'b0, 16'h0, 1'b0);
         if (obs_fd2) begin
            n_fd++;
            if (first_fd < 0) first_fd = c;
            else if (second_fd < 0) second_fd = c;
         end
      end
      check("p3_fd_first", 16'(first_fd), 16'd11);
      check("p3_fd_second", 16'(second_fd), 16'd23);
      check("p3_fd_count", 16'(n_fd), 16'd2);

      // Random loads (biased to zeros), occasional reset, extra loads on the wrap cycle.
      cyc(1'b0, 16'h0, 1'b1);
      for (int c = 0; c < 1200; c++) begin
         for (int i = 0; i < N; i++)
            d[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         r  = ($urandom_range(0, 299) == 0);
         ld = ($urandom_range(0, 11) == 0);
         if (t % (N * P) == N * P - 1 && $urandom_range(0, 1) == 1) ld = 1'b1;
         cyc(ld, d, r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Time-multiplexes up to NUM_DIGITS 4-bit digit codes onto one shared 7-segment decoder in the parking-system display path.
- Sits directly upstream of the 7-segment code converter.
  - Drives the converter's 4-bit input.
  - Drives active-low digit anodes.
- Inserts a dead-time blank between digits to suppress ghosting.
- Displayed values are double-buffered, so a frame never shows a mix of old and new values.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- PRESCALE, 50000: clock cycles per digit slot, blank portion included (must be > BLANK_CYCLES).
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot (>= 1).

Ports:
- clk  in  1: single system clock; all logic is on its rising edge.
- rst  in  1: synchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS: digit codes; digit k is bits [4k+3:4k]; digit 0 is least significant/rightmost. Codes 0-9 are numerals, 10-12 are A/b/C, 13-15 are blank.
- load  in  1: one-cycle strobe; captures digits_in into the pending buffer.
- digit_out  out  4: code for the shared decoder; 4'hF (blank) when no anode is active.
- an_n  out  NUM_DIGITS: active-low anode enables; at most one bit is low.
- frame_done  out  1: one-cycle pulse at the end of each full scan.

Behaviour:
- Reset, synchronous, takes priority over everything:
  - digit_out=4'hF, an_n=all 1, frame_done=0.
  - Pending and shadow buffers = all 4'hF; pending_valid=0.
  - Digit index=0, slot counter=0, FSM=BLANK.
- Reset asserted mid-slot or mid-frame aborts the scan immediately. Values loaded before reset are discarded.
- Timing after reset release:
  - Cycle 0 is the first cycle with rst low.
  - Slot k (k=0..NUM_DIGITS-1) covers cycles [k*PRESCALE, (k+1)*PRESCALE) and repeats every NUM_DIGITS*PRESCALE cycles.
- FSM, two states:
  - BLANK: first BLANK_CYCLES cycles of a slot. an_n=all 1, digit_out=4'hF.
  - SHOW: remaining PRESCALE-BLANK_CYCLES cycles. an_n bit k=0 (others 1), digit_out=shadow digit k.
  - BLANK->SHOW when the slot counter reaches BLANK_CYCLES.
  - SHOW->BLANK on the last cycle of the slot. The index then increments, wrapping NUM_DIGITS-1 -> 0.
- All outputs are registered and glitch-free. The slot counter is ceil(log2(PRESCALE)) bits and wraps at PRESCALE-1 -> 0.
- frame_done:
  - High exactly during the last cycle of slot NUM_DIGITS-1.
  - Pulses every NUM_DIGITS*PRESCALE cycles.
- Buffering:
  - load=1 writes digits_in into pending and sets pending_valid. Back-to-back loads: the last one wins.
  - At the frame-wrap edge (the edge ending the frame_done cycle), if pending_valid, shadow<=pending and pending_valid<=0.
  - A new shadow value is first visible in slot 0 of the next frame.
  - load on the frame_done cycle itself: the wrap transfers the old pending contents, the new value lands in pending with pending_valid=1, and it is displayed one frame later.
  - load with no wrap pending leaves the display unchanged until the next wrap.
- Codes 13-15 pass through unchanged; the downstream decoder blanks them. The anode is still driven in SHOW.

Optional Feature:
- Macro: SEG_SCANNER_LZ_BLANK_EN.
- When defined (leading-zero blanking):
  - While transferring to shadow, each digit k>0 whose value is 0 and whose more-significant digits are all 0 or blank is stored as 4'hF.
  - During SHOW of such a digit, an_n stays all 1.
  - Digit 0 is never blanked.
- When undefined, shadow is a verbatim copy of pending and zeros display normally.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 unless stated):
- Reset, then no load: for 64 cycles, an_n walks 1110, 1101, 1011, 0111 in cycles 2-7, 10-15, 18-23, 26-31. an_n=1111 in cycles 0-1, 8-9, and so on. digit_out=4'hF throughout. frame_done is high in cycles 31 and 63 only.
- load with digits_in=16'hC942 at cycle 3: frame 0 stays blank; cycles 34-39 show digit_out=2 with an_n=1110, and cycles 58-63 show digit_out=C with an_n=0111.
- load 16'h1234 at cycle 31 (the frame_done cycle), after 16'h5678 was loaded at cycle 10: frame 1 shows 8,7,6,5 and frame 2 shows 4,3,2,1.
- rst asserted at cycle 20 for 1 cycle, after a load in frame 0: outputs are back at reset values the next cycle, and the scan restarts at slot 0 with a blank display.
- SEG_SCANNER_LZ_BLANK_EN defined, load 16'h0070: digits 3 and 2 keep an_n=1111 during their SHOW; digit 1 shows 7 and digit 0 shows 0. Without the macro, digits 3 and 2 show 0.
- PRESCALE=3, BLANK_CYCLES=1: each slot has 1 blank cycle and 2 show cycles, and frame_done has a 12-cycle period.
